// File: rtl/inv_shift_rows_pipe.sv
// rtl/inv_shift_rows_pipe.sv - AES-128 InvShiftRows stage with registered output and skid slot
// Optional INV_SR_TAG_EN carries a 4-bit tag with each block through both slots.
module inv_shift_rows_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     D_in,
`ifdef INV_SR_TAG_EN
  input  logic [3:0]       tag_in,
  output logic [3:0]       tag_out,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     D_out,
  output logic [CNT_W-1:0] blk_cnt
);

  // State encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [127:0]     main_data_q, main_data_d;
  logic [127:0]     skid_data_q, skid_data_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
`ifdef INV_SR_TAG_EN
  logic [3:0]       main_tag_q, main_tag_d;
  logic [3:0]       skid_tag_q, skid_tag_d;
`endif

  logic in_xfer;
  logic out_xfer;
  logic load_main_in;
  logic load_skid_in;
  logic load_main_skid;

  // out(r,c) = in(r,(c-r) mod 4), byte k = 4*col+row counted from the MSB.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * src -: 8];
      end
    end
    return o;
  endfunction

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      blk_cnt_q   <= '0;
`ifdef INV_SR_TAG_EN
      main_tag_q  <= '0;
      skid_tag_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      blk_cnt_q   <= blk_cnt_d;
`ifdef INV_SR_TAG_EN
      main_tag_q  <= main_tag_d;
      skid_tag_q  <= skid_tag_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) state_d = ST_ONE;
        ST_ONE: begin
          if (in_xfer && !out_xfer)      state_d = ST_FULL;
          else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_xfer) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready       = ~state_q[0];
    out_valid      = state_q[1];
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    // A flush discards whatever would have been captured this cycle.
    if (!flush) begin
      case (state_q)
        ST_EMPTY: load_main_in = in_valid;
        ST_ONE: begin
          load_main_in = in_valid & out_ready;
          load_skid_in = in_valid & ~out_ready;
        end
        ST_FULL:  load_main_skid = out_ready;
        default:  ;
      endcase
    end
  end

  always_comb begin
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (load_main_in)        main_data_d = inv_shift_rows(D_in);
    else if (load_main_skid) main_data_d = skid_data_q;
    if (load_skid_in)        skid_data_d = inv_shift_rows(D_in);
    blk_cnt_d = blk_cnt_q + CNT_W'(out_xfer & ~flush);
  end

`ifdef INV_SR_TAG_EN
  always_comb begin
    main_tag_d = main_tag_q;
    skid_tag_d = skid_tag_q;
    if (load_main_in)        main_tag_d = tag_in;
    else if (load_main_skid) main_tag_d = skid_tag_q;
    if (load_skid_in)        skid_tag_d = tag_in;
  end

  assign tag_out = main_tag_q;
`endif

  assign D_out   = main_data_q;
  assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_inv_shift_rows_pipe.sv
// tb/tb_inv_shift_rows_pipe.sv - directed and round-trip checks for inv_shift_rows_pipe
module tb_inv_shift_rows_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [127:0] D_in;
  logic         out_ready;
  logic         in_ready, in_ready4;
  logic         out_valid, out_valid4;
  logic [127:0] D_out, D_out4;
  logic [15:0]  blk_cnt;
  logic [3:0]   blk_cnt4;
`ifdef INV_SR_TAG_EN
  logic [3:0]   tag_out, tag_out4;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] x [0:4];

  always #5 clk = ~clk;

  inv_shift_rows_pipe #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .D_in(D_in),
`ifdef INV_SR_TAG_EN
    .tag_in(4'h0), .tag_out(tag_out),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .D_out(D_out), .blk_cnt(blk_cnt)
  );

  inv_shift_rows_pipe #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .D_in(D_in),
`ifdef INV_SR_TAG_EN
    .tag_in(4'h0), .tag_out(tag_out4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready), .D_out(D_out4), .blk_cnt(blk_cnt4)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Forward ShiftRows: out(r,c) = in(r,(c+r) mod 4); its inverse must restore the block.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
  endtask

  task automatic stream(input int n, input string tag);
    logic [127:0] b;
    out_ready = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < n; i++) begin
      b        = rand_block();
      D_in     = shift_rows(b);
      in_valid = 1'b1;
      tick();
      check({tag, "_data"}, D_out, b);
      check({tag, "_valid"}, 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    D_in      = shift_rows(x[0]);
    in_valid  = 1'b1;
    tick();
    D_in      = shift_rows(x[1]);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) x[i] = rand_block();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; D_in = '0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_d_out",     D_out,           128'd0);
    check("rst_blk_cnt",   128'(blk_cnt),   128'd0);
    tick();
    tick();
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    D_in      = 128'h000102030405060708090a0b0c0d0e0f;
    tick();
    check("vec1_data",  D_out, 128'h000d0a0704010e0b0805020f0c090603);
    check("vec1_valid", 128'(out_valid), 128'd1);
    check("vec1_cnt",   128'(blk_cnt), 128'd0);
    D_in = 128'h00112233445566778899aabbccddeeff;
    tick();
    check("vec2_data", D_out, 128'h00ddaa774411eebb885522ffcc996633);
    check("vec2_cnt",  128'(blk_cnt), 128'd1);
    in_valid = 1'b0;
    tick();
    check("vec_drain_valid", 128'(out_valid), 128'd0);
    check("vec_drain_cnt",   128'(blk_cnt), 128'd2);

    // Back-to-back stream of 8.
    pulse_reset();
    stream(8, "b2b");
    check("b2b_cnt16", 128'(blk_cnt),   128'd8);
    check("b2b_cnt4",  128'(blk_cnt4),  128'd8);
    check("b2b_idle",  128'(out_valid), 128'd0);

    stream(1000, "rt");

    // Backpressure: two accepted, third held off, D_out stable.
    pulse_reset();
    fill_two();
    check("bp_in_ready_full", 128'(in_ready), 128'd0);
    check("bp_d_out_first",   D_out, x[0]);
    D_in = shift_rows(x[2]);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_d_out_stable",  D_out, x[0]);
      check("bp_in_ready_held", 128'(in_ready), 128'd0);
      check("bp_valid_held",    128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_rel_d1",    D_out, x[1]);
    check("bp_rel_ready", 128'(in_ready), 128'd1);
    check("bp_rel_cnt1",  128'(blk_cnt), 128'd1);
    tick();
    check("bp_rel_d2",   D_out, x[2]);
    check("bp_rel_cnt2", 128'(blk_cnt), 128'd2);
    in_valid = 1'b0;
    tick();
    check("bp_rel_empty", 128'(out_valid), 128'd0);
    check("bp_rel_cnt3",  128'(blk_cnt), 128'd3);

    // Flush with skid full, then flush discarding a simultaneous input.
    pulse_reset();
    fill_two();
    D_in  = shift_rows(x[2]);
    flush = 1'b1;
    tick();
    check("fl_valid",    128'(out_valid), 128'd0);
    check("fl_in_ready", 128'(in_ready),  128'd1);
    check("fl_cnt",      128'(blk_cnt),   128'd0);
    flush = 1'b0;
    D_in  = shift_rows(x[3]);
    tick();
    check("fl_one_data", D_out, x[3]);
    D_in      = shift_rows(x[4]);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    check("fl_one_valid", 128'(out_valid), 128'd0);
    check("fl_one_cnt",   128'(blk_cnt),   128'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("fl_discard", 128'(out_valid), 128'd0);

    // Asynchronous reset while FULL, then counter wrap on the 4-bit instance.
    pulse_reset();
    stream(2, "pre");
    fill_two();
    check("ar_full", 128'(in_ready), 128'd0);
    rst = 1'b1;
    #2;
    check("ar_valid",    128'(out_valid), 128'd0);
    check("ar_d_out",    D_out,           128'd0);
    check("ar_cnt",      128'(blk_cnt),   128'd0);
    check("ar_in_ready", 128'(in_ready),  128'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    stream(17, "wrap");
    check("wrap_cnt4",  128'(blk_cnt4), 128'd1);
    check("wrap_cnt16", 128'(blk_cnt),  128'd17);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
